// File: rtl/led_pkg.sv
// Shared definitions for the LED mode path.
// Holds the number of display modes, the width of the mode code and a named
// constant for each mode code. The mode sequencer and the mode decoder both
// import this package so the two sides always agree on the encoding.
`timescale 1ns/1ps
package led_pkg;

  localparam int NUM_MODES = 6;
  localparam int CHOOSER_W = 3;

  localparam logic [CHOOSER_W-1:0] MODE_0 = 3'd0;
  localparam logic [CHOOSER_W-1:0] MODE_1 = 3'd1;
  localparam logic [CHOOSER_W-1:0] MODE_2 = 3'd2;
  localparam logic [CHOOSER_W-1:0] MODE_3 = 3'd3;
  localparam logic [CHOOSER_W-1:0] MODE_4 = 3'd4;
  localparam logic [CHOOSER_W-1:0] MODE_5 = 3'd5;

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// btn_debounce: conditions one raw push-button.
// A 2-flop synchroniser brings the raw level into the clk domain. The
// debounced level follows the synced level only after the two have differed
// for DB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
// A registered one-cycle press pulse marks each 0->1 change of the debounced
// level. Release gives no pulse, and a held button gives exactly one.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   btn_raw  in   raw button level, active-high, asynchronous to clk
//   press    out  one-cycle pulse when the debounced level rises
`timescale 1ns/1ps
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  // One extra state so the counter is at least one bit wide even for DB_CYCLES=1.
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_meta;
  logic             sync_level;
  logic             db_level;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      db_level   <= 1'b0;
      db_cnt     <= '0;
      press      <= 1'b0;
    end else begin
      sync_meta  <= btn_raw;
      sync_level <= sync_meta;
      press      <= 1'b0;
      if (sync_level == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        // This is the DB_CYCLES-th consecutive differing cycle: accept the level.
        db_cnt   <= '0;
        db_level <= sync_level;
        press    <= sync_level;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: owns the display mode code for the LED driver.
// Two debounced buttons step the mode up (next) or down (prev); with auto_en
// high a dwell counter also steps it up every DWELL_CYCLES cycles. The code
// wraps explicitly inside 0..NUM_MODES-1.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_next     in   raw "next" button, active-high, asynchronous
//   btn_prev     in   raw "prev" button, active-high, asynchronous
//   auto_en      in   synchronous level, 1 enables auto-cycling
//   chooser      out  registered mode code to the mode decoder
//   mode_change  out  one-cycle pulse in the cycle chooser takes a new value
//
// Update priority each cycle: both events (ignored), next, prev, auto tick.
// Any manual event restarts the dwell period; a tick that coincides with a
// manual event is dropped.
`timescale 1ns/1ps
module led_mode_sequencer #(
  parameter int NUM_MODES    = led_pkg::NUM_MODES,
  parameter int CHOOSER_W    = led_pkg::CHOOSER_W,
  parameter int DB_CYCLES    = 500000,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 auto_en,
  output logic [CHOOSER_W-1:0] chooser,
  output logic                 mode_change
);

  localparam logic [CHOOSER_W-1:0] FIRST_MODE = CHOOSER_W'(led_pkg::MODE_0);
  localparam logic [CHOOSER_W-1:0] LAST_MODE  = CHOOSER_W'(NUM_MODES - 1);
  localparam int                   DW_W       = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW_W-1:0]      DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  logic                 next_evt;
  logic                 prev_evt;
  logic                 manual_evt;
  logic                 auto_tick;
  logic [DW_W-1:0]      dwell_cnt;
  logic [DW_W-1:0]      dwell_nxt;
  logic [CHOOSER_W-1:0] chooser_nxt;
  logic [CHOOSER_W-1:0] chooser_inc;
  logic [CHOOSER_W-1:0] chooser_dec;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .press   (next_evt)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_prev),
    .press   (prev_evt)
  );

  assign manual_evt = next_evt | prev_evt;
  assign auto_tick  = auto_en && (dwell_cnt == DWELL_LAST);

  // Explicit wrap so codes NUM_MODES..2^CHOOSER_W-1 are never produced.
  assign chooser_inc = (chooser == LAST_MODE)  ? FIRST_MODE : chooser + CHOOSER_W'(1);
  assign chooser_dec = (chooser == FIRST_MODE) ? LAST_MODE  : chooser - CHOOSER_W'(1);

  always_comb begin
    chooser_nxt = chooser;
    if (next_evt && prev_evt) begin
      chooser_nxt = chooser;
    end else if (next_evt) begin
      chooser_nxt = chooser_inc;
    end else if (prev_evt) begin
      chooser_nxt = chooser_dec;
    end else if (auto_tick) begin
      chooser_nxt = chooser_inc;
    end
  end

  // Counter restarts on disable, on any manual event and after each tick.
  always_comb begin
    dwell_nxt = dwell_cnt + DW_W'(1);
    if (!auto_en || manual_evt || auto_tick) begin
      dwell_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chooser     <= FIRST_MODE;
      mode_change <= 1'b0;
      dwell_cnt   <= '0;
    end else begin
      chooser     <= chooser_nxt;
      mode_change <= (chooser_nxt != chooser);
      dwell_cnt   <= dwell_nxt;
    end
  end

endmodule
